// File: rtl/por_reset_sequencer_pkg.sv
// por_pkg: shared state, cause encodings and counter sizing for the reset sequencer
package por_pkg;
  typedef enum logic [1:0] {HOLD, STRETCH, STAGE, RUN} state_e;
  localparam logic [1:0] CAUSE_POR    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_LOCK   = 2'd2;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/por_reset_sequencer_sync_debounce.sv
// sync_debounce: multi-flop synchronizer with an optional level debouncer (DEBOUNCE_CYCLES=0 bypasses it)
module sync_debounce #(
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign q_o = sync_q[STAGES-1];
  end else begin : g_db
    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    logic db_q, db_d, diff, flip;
    assign diff = sync_q[STAGES-1] != db_q;
    assign flip = diff && cnt_q == W'(DEBOUNCE_CYCLES - 1);
    always_comb begin
      db_d  = flip ? ~db_q : db_q;
      cnt_d = (!diff || flip) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        db_q  <= db_d;
      end
    assign q_o = db_q;
  end
endmodule

// File: rtl/por_reset_sequencer.sv
// por_reset_sequencer: staged synchronous release of VGA then game resets, with last-reset cause
module por_reset_sequencer
  import por_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STRETCH_CYCLES  = 16,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_reset,
  output logic       rst_vga_n,
  output logic       rst_game_n,
  output logic       sys_ready,
  output logic [1:0] reset_cause
);
  localparam int CW = cnt_width(STRETCH_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic vga_q, vga_d, run_q, run_d;
  logic locked_s, btn_db;
  sync_debounce #(.STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0)) u_lock (
    .clk(clk), .rst_n(rst_n), .d_i(pll_locked), .q_o(locked_s)
  );
  sync_debounce #(.STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk), .rst_n(rst_n), .d_i(btn_reset), .q_o(btn_db)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      cause_q <= CAUSE_POR;
      vga_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      vga_q   <= vga_d;
      run_q   <= run_d;
    end
  // Lock loss outranks the button when both abort in the same cycle.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (state_q != HOLD && (!locked_s || btn_db)) begin
      state_d = HOLD;
      cause_d = locked_s ? CAUSE_BUTTON : CAUSE_LOCK;
    end else begin
      case (state_q)
        HOLD:    if (locked_s && !btn_db) state_d = STRETCH;
        STRETCH: if (cnt_q == CW'(STRETCH_CYCLES - 1)) state_d = STAGE;
        STAGE:   if (cnt_q == CW'(STAGE_GAP - 1)) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
    cnt_d = (state_d != state_q || state_q == HOLD || state_q == RUN) ? '0 : cnt_q + 1'b1;
  end
  always_comb begin
    vga_d = state_d == STAGE || state_d == RUN;
    run_d = state_d == RUN;
  end
  assign rst_vga_n   = vga_q;
  assign rst_game_n  = run_q;
  assign sys_ready   = run_q;
  assign reset_cause = cause_q;
endmodule
